// File: rtl/fft_src_gen_pkg.sv
// Shared types and helpers for the FFT frame source and its address map.
package fft_src_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LINEAR = 2'b00,
    BITREV = 2'b01,
    DECIM  = 2'b10,
    RSVD   = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int unsigned clamp_log2n(input int unsigned log2n,
                                              input int unsigned max_n);
    return (log2n > max_n) ? max_n : log2n;
  endfunction

endpackage

// File: rtl/fft_src_gen_if.sv
// Control and sample-stream bundle between the frame source and its consumer.
interface fft_src_gen_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LOG2_W     = $clog2(ADDR_WIDTH + 1)
);
  logic                  enb_cg_i;
  logic                  start_i;
  logic                  stop_i;
  logic                  cont_i;
  logic [1:0]            mode_i;
  logic [LOG2_W-1:0]     log2n_i;
  logic [DATA_WIDTH-1:0] seed_i;
  logic                  rdy_i;
  logic                  vld_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] dt_o;
  logic                  sof_o;
  logic                  eof_o;
  logic                  busy_o;
  logic                  done_o;

  // The frame source is the stream master.
  modport master (
    input  enb_cg_i, start_i, stop_i, cont_i, mode_i, log2n_i, seed_i, rdy_i,
    output vld_o, addr_o, dt_o, sof_o, eof_o, busy_o, done_o
  );

  modport slave (
    output enb_cg_i, start_i, stop_i, cont_i, mode_i, log2n_i, seed_i, rdy_i,
    input  vld_o, addr_o, dt_o, sof_o, eof_o, busy_o, done_o
  );
endinterface

// File: rtl/fft_src_addr_map.sv
// Combinational sample-index to address map: linear, bit-reversed or even/odd decimated.
module fft_src_addr_map
  import fft_src_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LOG2_W     = $clog2(ADDR_WIDTH + 1)
) (
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  logic [LOG2_W-1:0]     n_i,
  input  mode_e                 mode_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);
  logic [ADDR_WIDTH-1:0] w_ones;
  logic [ADDR_WIDTH-1:0] w_mask;
  logic [ADDR_WIDTH-1:0] w_half;
  logic [ADDR_WIDTH-1:0] w_rev_full;
  logic [ADDR_WIDTH-1:0] w_rev;
  logic [ADDR_WIDTH-1:0] w_dec;
  logic [ADDR_WIDTH-1:0] w_raw;
  logic [LOG2_W-1:0]     w_rsh;

  assign w_ones = '1;
  assign w_mask = ~(w_ones << n_i);
  assign w_half = ADDR_WIDTH'(((ADDR_WIDTH + 1)'(1) << n_i) >> 1);

  // Reverse the full word, then drop the unused low bits to reverse only idx[n-1:0].
  assign w_rev_full = {<<{idx_i}};
  assign w_rsh      = LOG2_W'(ADDR_WIDTH) - n_i;
  assign w_rev      = w_rev_full >> w_rsh;

  assign w_dec = (idx_i < w_half) ? (idx_i << 1)
                                  : (((idx_i - w_half) << 1) | ADDR_WIDTH'(1));

  always_comb begin
    w_raw = idx_i;
    case (mode_i)
      BITREV:  w_raw = w_rev;
      DECIM:   w_raw = w_dec;
      default: w_raw = idx_i;
    endcase
    addr_o = w_raw & w_mask;
  end
endmodule

// File: rtl/fft_src_gen.sv
// FFT frame source: FSM, index counter, config latch and registered sample stream.
module fft_src_gen
  import fft_src_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LOG2_W     = $clog2(ADDR_WIDTH + 1)
) (
  input logic           clk_cg_i,
  input logic           rst_b_i,
  fft_src_gen_if.master bus
);
  state_e                r_state;
  mode_e                 r_mode;
  logic [LOG2_W-1:0]     r_n;
  logic                  r_cont;
  logic                  r_stop_pend;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_vld;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_dt;
  logic                  r_sof;
  logic                  r_eof;
  logic                  r_busy;
  logic                  r_done;

  logic [LOG2_W-1:0]     w_n_in;
  logic [LOG2_W-1:0]     w_map_n;
  mode_e                 w_map_mode;
  logic [ADDR_WIDTH-1:0] w_len_m1;
  logic [ADDR_WIDTH-1:0] w_idx_nxt;
  logic [ADDR_WIDTH-1:0] w_map_idx;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_last;
  logic                  w_end;

  assign w_n_in = LOG2_W'(clamp_log2n(32'(bus.log2n_i), ADDR_WIDTH));

  // In IDLE the map sees the incoming config so idx 0 is ready right after the start edge.
  assign w_map_n    = (r_state == IDLE) ? w_n_in : r_n;
  assign w_map_mode = (r_state == IDLE) ? mode_e'(bus.mode_i) : r_mode;
  assign w_len_m1   = ADDR_WIDTH'(((ADDR_WIDTH + 1)'(1) << w_map_n) - 1'b1);
  assign w_last     = (r_idx == w_len_m1);
  assign w_idx_nxt  = w_last ? '0 : r_idx + 1'b1;
  assign w_map_idx  = (r_state == IDLE) ? '0 : w_idx_nxt;
  // A stop arriving on the eof transfer itself still ends the run there.
  assign w_end      = ~r_cont | r_stop_pend | bus.stop_i;

  fft_src_addr_map #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LOG2_W     (LOG2_W)
  ) u_addr_map (
    .idx_i  (w_map_idx),
    .n_i    (w_map_n),
    .mode_i (w_map_mode),
    .addr_o (w_addr_nxt)
  );

  always_ff @(posedge clk_cg_i) begin
    if (!rst_b_i) begin
      r_state     <= IDLE;
      r_mode      <= LINEAR;
      r_n         <= '0;
      r_cont      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_seed      <= '0;
      r_idx       <= '0;
      r_vld       <= 1'b0;
      r_addr      <= '0;
      r_dt        <= '0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (bus.enb_cg_i) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_state     <= RUN;
            r_mode      <= w_map_mode;
            r_n         <= w_n_in;
            r_cont      <= bus.cont_i;
            r_seed      <= bus.seed_i;
            r_stop_pend <= bus.stop_i;
            r_idx       <= '0;
            r_vld       <= 1'b1;
            r_busy      <= 1'b1;
            r_addr      <= w_addr_nxt;
            r_dt        <= bus.seed_i;
            r_sof       <= 1'b1;
            r_eof       <= (w_len_m1 == '0);
          end
        end
        RUN: begin
          if (bus.stop_i) r_stop_pend <= 1'b1;
          if (r_vld && bus.rdy_i) begin
            if (w_last && w_end) begin
              r_state     <= IDLE;
              r_stop_pend <= 1'b0;
              r_vld       <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_sof       <= 1'b0;
              r_eof       <= 1'b0;
            end else begin
              r_idx  <= w_idx_nxt;
              r_addr <= w_addr_nxt;
              r_dt   <= r_seed + DATA_WIDTH'(w_idx_nxt);
              r_sof  <= (w_idx_nxt == '0);
              r_eof  <= (w_idx_nxt == w_len_m1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.vld_o  = r_vld;
  assign bus.addr_o = r_addr;
  assign bus.dt_o   = r_dt;
  assign bus.sof_o  = r_sof;
  assign bus.eof_o  = r_eof;
  assign bus.busy_o = r_busy;
  assign bus.done_o = r_done;
endmodule

// File: tb/tb_fft_src_gen.sv
// Self-checking bench for fft_src_gen: behavioural model, directed cases and random traffic.
module tb_fft_src_gen;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = $clog2(AW + 1);

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  fft_src_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOG2_W(LW)) bus ();

  fft_src_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOG2_W(LW)) dut (
    .clk_cg_i (clk),
    .rst_b_i  (rst_b),
    .bus      (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] dt;
    logic          sof;
    logic          eof;
  } xfer_t;

  xfer_t xlog[$];
  int n_checks = 0;
  int n_pass   = 0;

  int exp_lin[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int exp_rev[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int exp_dec[8] = '{0, 2, 4, 6, 1, 3, 5, 7};

  // Model state: what the DUT must present after the most recent clock edge.
  bit m_ok = 0, m_busy = 0, m_done = 0, m_cont = 0, m_pend = 0, m_rstchk = 0;
  int m_mode = 0, m_n = 0, m_idx = 0, m_seed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int ref_addr(input int mode, input int n, input int idx);
    int len;
    int r;
    len = 1 << n;
    r = 0;
    if (n == 0) return 0;
    if (mode == 1) begin
      for (int b = 0; b < n; b++) if (((idx >> b) & 1) != 0) r = r | (1 << (n - 1 - b));
      return r;
    end
    if (mode == 2) return (idx < len / 2) ? 2 * idx : 2 * (idx - len / 2) + 1;
    return idx;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        check("busy", 32'(bus.busy_o), 32'(m_busy));
        check("vld", 32'(bus.vld_o), 32'(m_busy));
        check("done", 32'(bus.done_o), 32'(m_done));
        if (m_busy) begin
          check("addr", 32'(bus.addr_o), ref_addr(m_mode, m_n, m_idx));
          check("dt", 32'(bus.dt_o), (m_seed + m_idx) & 32'hFFFF);
          check("sof", 32'(bus.sof_o), 32'(m_idx == 0));
          check("eof", 32'(bus.eof_o), 32'(m_idx == (1 << m_n) - 1));
        end
        if (m_rstchk) begin
          check("rst_addr", 32'(bus.addr_o), 0);
          check("rst_dt", 32'(bus.dt_o), 0);
          check("rst_sof", 32'(bus.sof_o), 0);
          check("rst_eof", 32'(bus.eof_o), 0);
        end
      end
      if (rst_b && bus.vld_o && bus.rdy_i && bus.enb_cg_i)
        xlog.push_back('{addr: bus.addr_o, dt: bus.dt_o, sof: bus.sof_o, eof: bus.eof_o});
      // Advance the model across the coming edge.
      if (!rst_b) begin
        m_ok = 1; m_busy = 0; m_done = 0; m_pend = 0; m_idx = 0; m_rstchk = 1;
      end else begin
        m_rstchk = 0;
        if (bus.enb_cg_i) begin
          m_done = 0;
          if (!m_busy) begin
            if (bus.start_i) begin
              m_busy = 1;
              m_mode = int'(bus.mode_i);
              m_n    = (int'(bus.log2n_i) > int'(AW)) ? int'(AW) : int'(bus.log2n_i);
              m_seed = int'(bus.seed_i);
              m_cont = bus.cont_i;
              m_pend = bus.stop_i;
              m_idx  = 0;
            end
          end else begin
            if (bus.stop_i) m_pend = 1;
            if (bus.rdy_i) begin
              if (m_idx == (1 << m_n) - 1) begin
                if (!m_cont || m_pend) begin
                  m_busy = 0; m_done = 1; m_pend = 0;
                end else m_idx = 0;
              end else m_idx++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int mode, input int l2n, input int seed, input bit cont);
    bus.mode_i  = 2'(mode);
    bus.log2n_i = LW'(l2n);
    bus.seed_i  = DW'(seed);
    bus.cont_i  = cont;
  endtask

  task automatic start_run(input bit with_stop);
    xlog.delete();
    bus.enb_cg_i = 1'b1;
    bus.start_i  = 1'b1;
    bus.stop_i   = with_stop;
    step();
    bus.start_i  = 1'b0;
    bus.stop_i   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (m_busy && c < budget) begin
      step();
      c++;
    end
    check("idle_wait", 32'(m_busy), 0);
  endtask

  task automatic wait_log(input int n, input int budget);
    int c;
    c = 0;
    while (xlog.size() < n && c < budget) begin
      step();
      c++;
    end
    check("log_wait", 32'(xlog.size() >= n), 1);
  endtask

  task automatic check_seq(input string tag, input int exp_a[8], input int seed);
    check({tag, "_cnt"}, 32'(xlog.size()), 8);
    for (int i = 0; i < 8 && i < xlog.size(); i++) begin
      check({tag, "_addr"}, 32'(xlog[i].addr), exp_a[i]);
      check({tag, "_dt"}, 32'(xlog[i].dt), (seed + i) & 32'hFFFF);
      check({tag, "_sof"}, 32'(xlog[i].sof), 32'(i == 0));
      check({tag, "_eof"}, 32'(xlog[i].eof), 32'(i == 7));
    end
  endtask

  initial begin
    int c;
    bus.enb_cg_i = 1'b1; bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.rdy_i = 1'b1;
    setup(0, 0, 0, 0);
    repeat (2) step();
    rst_b = 1'b1;
    step();

    // Linear frame with done pulse.
    setup(0, 3, 'h10, 0);
    start_run(0);
    wait_idle(100);
    check("lin_done", 32'(bus.done_o), 1);
    step();
    check("lin_done_pulse", 32'(bus.done_o), 0);
    check_seq("lin", exp_lin, 'h10);

    setup(1, 3, 'h10, 0);
    start_run(0);
    wait_idle(100);
    check_seq("rev", exp_rev, 'h10);

    setup(2, 3, 'h10, 0);
    start_run(0);
    wait_idle(100);
    check_seq("dec", exp_dec, 'h10);

    // Back-pressure via rdy_i, then via enb_cg_i.
    setup(0, 3, 'h10, 0);
    start_run(0);
    wait_log(2, 50);
    bus.rdy_i = 1'b0;
    repeat (3) step();
    check("bp_addr_held", 32'(bus.addr_o), 2);
    check("bp_dt_held", 32'(bus.dt_o), 'h12);
    bus.rdy_i = 1'b1;
    wait_idle(100);
    check_seq("bp", exp_lin, 'h10);

    setup(0, 3, 'h10, 0);
    start_run(0);
    wait_log(2, 50);
    bus.enb_cg_i = 1'b0;
    repeat (3) step();
    check("cg_addr_held", 32'(bus.addr_o), 2);
    check("cg_vld_held", 32'(bus.vld_o), 1);
    bus.enb_cg_i = 1'b1;
    wait_idle(100);
    check_seq("cg", exp_lin, 'h10);

    // Continuous mode stopped during the third frame.
    setup(0, 2, 0, 1);
    start_run(0);
    wait_log(9, 100);
    bus.stop_i = 1'b1;
    step();
    bus.stop_i = 1'b0;
    wait_idle(100);
    check("cont_cnt", 32'(xlog.size()), 12);
    if (xlog.size() >= 12) begin
      check("cont_last_addr", 32'(xlog[11].addr), 3);
      check("cont_last_eof", 32'(xlog[11].eof), 1);
      check("cont_wrap_sof", 32'(xlog[8].sof), 1);
    end

    // Single-sample frame.
    setup(1, 0, 5, 0);
    start_run(0);
    wait_idle(20);
    check("n0_cnt", 32'(xlog.size()), 1);
    if (xlog.size() >= 1) begin
      check("n0_addr", 32'(xlog[0].addr), 0);
      check("n0_sof", 32'(xlog[0].sof), 1);
      check("n0_eof", 32'(xlog[0].eof), 1);
      check("n0_dt", 32'(xlog[0].dt), 5);
    end

    // Oversized exponent clamps to the full address range.
    setup(0, 15, 0, 0);
    start_run(0);
    wait_idle(400);
    check("clamp_cnt", 32'(xlog.size()), 256);
    if (xlog.size() >= 256) begin
      check("clamp_last_addr", 32'(xlog[255].addr), 255);
      check("clamp_last_eof", 32'(xlog[255].eof), 1);
    end

    // Start and stop together in continuous mode: one frame only.
    setup(2, 2, 0, 1);
    start_run(1);
    wait_idle(100);
    check("startstop_cnt", 32'(xlog.size()), 4);

    // Data wraps modulo 2^16.
    setup(0, 1, 'hFFFF, 0);
    start_run(0);
    wait_idle(20);
    check("wrap_cnt", 32'(xlog.size()), 2);
    if (xlog.size() >= 2) begin
      check("wrap_dt0", 32'(xlog[0].dt), 'hFFFF);
      check("wrap_dt1", 32'(xlog[1].dt), 0);
    end

    // Reset mid-frame, then a clean restart.
    setup(0, 3, 0, 0);
    start_run(0);
    wait_log(3, 50);
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    check("mid_rst_vld", 32'(bus.vld_o), 0);
    check("mid_rst_busy", 32'(bus.busy_o), 0);
    check("mid_rst_done", 32'(bus.done_o), 0);
    check("mid_rst_addr", 32'(bus.addr_o), 0);
    step();
    check("mid_rst_no_done", 32'(bus.done_o), 0);
    setup(0, 3, 'h10, 0);
    start_run(0);
    wait_idle(100);
    check_seq("restart", exp_lin, 'h10);

    // Random traffic against the model.
    for (int r = 0; r < 40; r++) begin
      setup(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), int'($urandom),
            bit'($urandom_range(0, 1)));
      bus.rdy_i = 1'b1;
      start_run($urandom_range(0, 3) == 0);
      c = 0;
      while (m_busy && c < 3000) begin
        bus.rdy_i    = ($urandom_range(0, 9) < 7);
        bus.enb_cg_i = ($urandom_range(0, 9) < 8);
        bus.stop_i   = (c > 200) || ($urandom_range(0, 49) == 0);
        bus.start_i  = ($urandom_range(0, 9) == 0);
        bus.mode_i   = 2'($urandom_range(0, 3));
        bus.seed_i   = DW'($urandom);
        step();
        c++;
      end
      bus.stop_i = 1'b0; bus.start_i = 1'b0; bus.enb_cg_i = 1'b1; bus.rdy_i = 1'b1;
      check("rnd_idle", 32'(m_busy), 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fft_src_gen.md
# fft_src_gen

Parametrised frame source for the FFT frontend: generates sample addresses and test data in linear, bit-reversed or even/odd-decimated order. It streams them over a valid/ready handshake, framed by start/end markers, and supports single-shot and continuous modes. The block sits where the simple free-running address counter sat, in front of the FFT input buffer. It keeps the clock-gating enable semantics and adds framing, ordering modes and back-pressure.

## Interface
- ADDR_WIDTH, 8: address width; maximum frame length 2^ADDR_WIDTH.
- DATA_WIDTH, 16: sample data width.
- LOG2_W, $clog2(ADDR_WIDTH+1): width of log2n_i.
- clk_cg_i  in  1  gated clock; sole clock.
- rst_b_i  in  1  synchronous, active-low reset.
- enb_cg_i  in  1  clock-gating qualifier. Low: all state frozen.
- start_i  in  1  start pulse; sampled only in IDLE with enb_cg_i=1.
- stop_i  in  1  request graceful stop at end of current frame.
- cont_i  in  1  continuous mode; latched at start.
- mode_i  in  2  address order: 00 linear, 01 bit-reversed, 10 even/odd decimated, 11 treated as 00. Latched at start.
- log2n_i  in  LOG2_W  frame length exponent, len=2^log2n_i. Values >ADDR_WIDTH clamp to ADDR_WIDTH. Latched at start.
- seed_i  in  DATA_WIDTH  data base value; latched at start.
- rdy_i  in  1  downstream ready.
- vld_o  out  1  sample valid.
- addr_o  out  ADDR_WIDTH  sample address.
- dt_o  out  DATA_WIDTH  sample data.
- sof_o  out  1  first sample of frame (qualified by vld_o).
- eof_o  out  1  last sample of frame (qualified by vld_o).
- busy_o  out  1  high while not IDLE.
- done_o  out  1  one-cycle pulse at end of run.

## Operation
- States:
  - IDLE→RUN on start_i & enb_cg_i.
  - RUN→IDLE after the eof transfer when the run ends, i.e. cont_i=0 latched, or a stop is pending.
  - Otherwise RUN wraps to the next frame.
- Transfer = vld_o & rdy_i & enb_cg_i. The index idx advances only on a transfer.
- vld_o stays high and all outputs stay stable in RUN until the transfer.
- Address map, where n = clamped log2n, and all bits above n are 0:
  - linear: addr = idx.
  - bitrev: addr = idx[n-1:0] reversed.
  - decimated: idx < len/2 → 2·idx; else 2·(idx−len/2)+1.
  - n=0: addr = 0 in every mode; sof_o = eof_o = 1 on the single sample.
- dt_o = seed + idx, modulo 2^DATA_WIDTH. idx is zero-extended or truncated to DATA_WIDTH.
- Frame wrap: idx resets to 0; the next frame reuses the latched configuration.
- stop_i in RUN sets a stop_pend flag. stop_pend is cleared on entry to IDLE.
- stop_i with start_i in IDLE: start taken, stop pending, so exactly one frame runs.
- stop_i in IDLE alone: ignored.
- start_i in RUN: ignored.
- enb_cg_i=0: no transfer, no state change, start_i/stop_i ignored. Outputs hold.
- Reset values: vld_o, addr_o, dt_o, sof_o, eof_o, busy_o, done_o = 0. State = IDLE, idx = 0, stop_pend = 0, latched config = 0.
- Reset mid-frame: synchronous return to IDLE. No done_o pulse.

## Timing
- Start accepted at edge k: vld_o=1, sof_o=1, addr for idx 0 visible after edge k; busy_o=1 same cycle.
- Outputs registered. A transfer at edge j presents the next sample after edge j (one sample per cycle at full throughput).
- Final transfer at edge j: vld_o=0, busy_o=0, done_o=1 for the cycle after edge j.
- A start_i sampled in that done cycle is accepted; first sample after the next edge. Minimum gap between runs is one idle cycle.
- Continuous wrap has no bubble: the sof sample follows the eof sample directly.

## Structure
- Package fft_src_pkg:
  - mode_e: LINEAR, BITREV, DECIM, RSVD.
  - state_e: IDLE, RUN.
  - Function clamp_log2n.
- Sub-module fft_src_addr_map: combinational idx, n, mode → addr, parametrised by ADDR_WIDTH. Reusable by the FFT output reorder logic.
- Top holds the FSM, idx counter, config latch, stop_pend and output registers.

## Test plan
- Linear: ADDR_WIDTH=8, log2n=3, mode 00, seed=0x10, rdy=1 → addr 0..7, dt 0x10..0x17, sof on 0, eof on 7, done_o one cycle after.
- Bitrev: log2n=3, mode 01 → addr 0,4,2,6,1,5,3,7. Decimated: mode 10 → 0,2,4,6,1,3,5,7.
- Back-pressure: rdy_i low for 3 cycles at idx 2 → addr/dt/vld held for 3 cycles. Same for enb_cg_i low with rdy_i high → no advance.
- Continuous: cont=1, log2n=2, stop_i pulsed at idx 1 of frame 2 → frame 2 completes (idx 3, eof), then IDLE plus done. 12 transfers total.
- Boundaries: log2n=0 → single sample with sof=eof=1. log2n=15 with ADDR_WIDTH=8 → 256 samples. start+stop same cycle → one frame. seed=0xFFFF → dt wraps to 0x0000.
- rst_b_i low mid-frame → next cycle all outputs 0, IDLE, no done_o. Restart then begins at idx 0.
